// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// A start request latches a word, a pattern and a mode bit. The word is then
// scanned LSB first, one bit per clock. Pattern occurrences are counted into a
// saturating counter, and the index of the first match is recorded.
module seq_detector_param #(
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned PAT_W   = 3,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned CNT_MAX = 4,
    localparam int unsigned IDX_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              busy,
    output logic              done,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  count,
    output logic              found,
    output logic [IDX_W-1:0]  first_pos
);

    // fill counts 0..PAT_W, so it needs one more code than the pattern length
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    localparam logic [FILL_W:0]    PAT_LEN  = (FILL_W + 1)'(PAT_W);
    localparam logic [FILL_W:0]    FILL_ONE = (FILL_W + 1)'(1);
    localparam logic [CNT_W-1:0]   CNT_LIM  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]   IDX_NONE = IDX_W'(DATA_W);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Captured scan operands
    logic [DATA_W-1:0] data_q, data_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              ovl_q, ovl_d;

    // Scan datapath
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Result registers
    logic              match_q, match_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              found_q, found_d;
    logic [IDX_W-1:0]  first_q, first_d;

    // Combinational helpers
    logic              scan_bit;
    logic [PAT_W:0]    shift_full;
    logic [PAT_W-1:0]  window_new;
    logic [FILL_W:0]   fill_plus;
    logic              hit;

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            data_q   <= '0;
            pat_q    <= '0;
            ovl_q    <= 1'b0;
            idx_q    <= '0;
            window_q <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
            count_q  <= '0;
            found_q  <= 1'b0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            pat_q    <= pat_d;
            ovl_q    <= ovl_d;
            idx_q    <= idx_d;
            window_q <= window_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            count_q  <= count_d;
            found_q  <= found_d;
            first_q  <= first_d;
        end
    end

    // Next-state and datapath update for the IDLE/SCAN/DONE sequence
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        idx_d    = idx_q;
        window_d = window_q;
        fill_d   = fill_q;
        match_d  = 1'b0;
        count_d  = count_q;
        found_d  = found_q;
        first_d  = first_q;

        // Shift the current bit in at the young end; the oldest bit ends up in
        // window[PAT_W-1]. Building PAT_W+1 bits and truncating covers PAT_W=1.
        scan_bit   = data_q[idx_q];
        shift_full = {window_q, scan_bit};
        window_new = shift_full[PAT_W-1:0];
        fill_plus  = {1'b0, fill_q} + FILL_ONE;
        hit        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d   = data_in;
                    pat_d    = pattern;
                    ovl_d    = overlap;
                    idx_d    = '0;
                    window_d = '0;
                    fill_d   = '0;
                    count_d  = '0;
                    found_d  = 1'b0;
                    first_d  = IDX_NONE;
                    state_d  = StScan;
                end
            end

            StScan: begin
                window_d = window_new;
                fill_d   = (fill_plus > PAT_LEN) ? fill_q : fill_plus[FILL_W-1:0];
                idx_d    = idx_q + IDX_ONE;

                // The window is valid once it holds PAT_W bits including this one
                hit = (fill_plus >= PAT_LEN) && (window_new == pat_q);
                if (hit) begin
                    match_d = 1'b1;
                    if (count_q < CNT_LIM) begin
                        count_d = count_q + CNT_ONE;
                    end
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = idx_q;
                    end
                    // Non-overlapping mode: the next match must use fresh bits
                    if (!ovl_q) begin
                        fill_d = '0;
                    end
                end

                if (idx_q == IDX_LAST) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decoded from state; results come straight from registers
    always_comb begin
        busy        = (state_q == StScan);
        done        = (state_q == StDone);
        match_pulse = match_q;
        count       = count_q;
        found       = found_q;
        first_pos   = first_q;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector for the switch-input front end. On a start request it latches a DATA_W-bit input word, a PAT_W-bit programmable pattern and a mode bit. It then scans the word one bit per clock, LSB (index 0) first, and counts pattern occurrences into a saturating counter. It reports match pulses, the position of the first match and a done strobe. It replaces the fixed-pattern, fixed-width detector feeding the display/LED path.

## Interface
- DATA_W, 10: width of the scanned word; must be ≥ PAT_W.
- PAT_W, 3: pattern length; range 1..DATA_W.
- CNT_W, 4: width of the count output.
- CNT_MAX, 4: saturation value of count; must be ≤ 2^CNT_W−1.
- IDX_W (derived, not overridable): $clog2(DATA_W+1), the width of first_pos.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  scan request; sampled only in IDLE.
- data_in  in  DATA_W  word to scan; captured at start acceptance.
- pattern  in  PAT_W  pattern to detect; captured at start acceptance.
- overlap  in  1  mode, captured at start acceptance.
  - 1: overlapping matches counted.
  - 0: non-overlapping matches only.
- busy  out  1  high while scanning.
- done  out  1  one-cycle strobe after the last bit is scanned.
- match_pulse  out  1  high for one cycle after each bit that completes a match.
- count  out  CNT_W  saturating match count; held after done until the next start.
- found  out  1  at least one match in the current or last scan.
- first_pos  out  IDX_W  index of the bit completing the first match.
  - Equals DATA_W if no match has occurred since start.

## Operation
- States: IDLE, SCAN, DONE.
  - busy = (state==SCAN).
  - done = (state==DONE).
- IDLE with start=1: capture data_in, pattern and overlap. Clear idx, window, fill, count and found; set first_pos to DATA_W; go to SCAN.
- IDLE with start=0: stay in IDLE; all outputs hold.
- SCAN, each cycle:
  - b = captured data[idx].
  - window ← {window[PAT_W-2:0], b}. For PAT_W=1, window ← b.
  - fill ← min(fill+1, PAT_W).
  - idx ← idx+1.
- The earliest-scanned bit sits in window[PAT_W-1]. Pattern bit PAT_W-1 is compared against the oldest bit, so pattern 3'b101 matches scan order 1,0,1.
- Match condition: fill+1 ≥ PAT_W and the new window equals the captured pattern. On a match:
  - match_pulse ← 1.
  - count ← count+1 if count < CNT_MAX, else hold at CNT_MAX.
  - If found=0: found ← 1 and first_pos ← idx.
  - If overlap=0: fill ← 0; window contents are don't-care.
- SCAN to DONE: when the bit with idx = DATA_W−1 is consumed.
- DONE to IDLE: unconditional, after 1 cycle.
- start in SCAN or DONE is ignored; no queuing.
- Saturation: match_pulse still fires for every match, including after count reaches CNT_MAX.

## Timing
- Reset (asynchronous, any state): state = IDLE; busy, done, match_pulse, count, found and first_pos are all 0; internal idx, fill and window are 0.
- Reset mid-scan aborts the scan. The first cycle after rst deasserts is IDLE.
- Start accepted at edge E0.
  - busy is high from E1 through E_DATA_W, i.e. DATA_W cycles.
  - done is high between E_DATA_W and E_DATA_W+1.
  - The block is back in IDLE after E_DATA_W+1.
- Back-to-back scans: start held high continuously is accepted every DATA_W+2 cycles.
- Bit idx is consumed at edge E(idx+1).
- match_pulse, count, found and first_pos update at the same edge that consumes the matching bit.
- Final count and first_pos are valid while done is high and are held until the next accepted start.
- data_in and pattern changes after acceptance have no effect on the scan in progress.

## Test plan
- Overlap on, DATA_W=10, PAT_W=3, pattern=3'b101, data_in=10'b0000010101:
  - match_pulse at the edges consuming idx 2 and idx 4.
  - count=2, first_pos=2, found=1.
  - busy high 10 cycles, then done high 1 cycle.
- Same stimulus with overlap=0: a single match at idx 2, so count=1 and first_pos=2.
- Saturation: pattern=3'b111, data_in=10'h3FF, overlap=1, CNT_MAX=4.
  - 8 match_pulses (idx 2..9).
  - count stops at 4.
- No match: data_in=0, pattern=3'b101.
  - count=0, found=0, first_pos=10, no match_pulse.
  - done still asserts after 10 busy cycles.
- Protocol:
  - start pulsed again during SCAN: ignored; result unchanged.
  - rst asserted at busy cycle 5: all outputs 0 immediately, state IDLE.
  - A fresh start after reset gives a correct full scan.
- PAT_W=1, pattern=1'b1, data_in=10'b1000000001:
  - count=2, first_pos=0.
  - match_pulse at the edges consuming idx 0 and idx 9.
